// File: rtl/prga_decrypt_if.sv
// prga_decrypt_if: start/status handshake plus S-RAM, message ROM and decrypted-RAM ports of the PRGA stage
interface prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              start_sig;
    logic              busy;
    logic              done;
    logic              key_invalid;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [MSG_AW-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;

    modport master (
        input  start_sig, s_q, rom_q,
        output busy, done, key_invalid, s_address, s_data, s_wren,
               rom_address, dec_address, dec_data, dec_wren
    );

    modport slave (
        output start_sig, s_q, rom_q,
        input  busy, done, key_invalid, s_address, s_data, s_wren,
               rom_address, dec_address, dec_data, dec_wren
    );
endinterface

// File: rtl/prga_decrypt.sv
// prga_decrypt: RC4 PRGA keystream generator and XOR decryptor, 13 cycles per byte; VALID_CHECK_EN enables the plaintext abort check
module prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic           clk,
    input  logic           reset,
    prga_decrypt_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, I_INC, SI_RD, SI_WT, SI_CAP, SJ_RD, SJ_WT, SJ_CAP,
        WR_SI, WR_SJ, F_RD, F_WT, F_CAP, WR_DEC, DONE
    } state_t;

    localparam logic [MSG_AW-1:0] LAST = MSG_AW'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic              done_q, done_d, kinv_q, kinv_d;
    logic [7:0]        plain;
    logic              bad;

    assign plain = f_q ^ enc_q;
`ifdef VALID_CHECK_EN
    assign bad = !((plain >= 8'h61 && plain <= 8'h7A) || plain == 8'h20);
`else
    assign bad = 1'b0;
`endif

    // state and datapath registers; reset aborts any run immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            enc_q   <= '0;
            done_q  <= 1'b0;
            kinv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
            done_q  <= done_d;
            kinv_q  <= kinv_d;
        end
    end

    // next-state, datapath updates and memory strobes for the per-byte sequence
    always_comb begin
        state_d         = state_q;
        i_d             = i_q;
        j_d             = j_q;
        k_d             = k_q;
        si_d            = si_q;
        sj_d            = sj_q;
        f_d             = f_q;
        enc_d           = enc_q;
        done_d          = done_q;
        kinv_d          = kinv_q;
        bus.busy        = !(state_q == IDLE || state_q == DONE);
        bus.done        = done_q;
        bus.key_invalid = kinv_q;
        bus.s_address   = '0;
        bus.s_data      = '0;
        bus.s_wren      = 1'b0;
        bus.rom_address = '0;
        bus.dec_address = '0;
        bus.dec_data    = '0;
        bus.dec_wren    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_sig) begin
                    state_d = I_INC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    done_d  = 1'b0;
                    kinv_d  = 1'b0;
                end else if (state_q == DONE) begin
                    done_d = 1'b1;
                end
            end
            I_INC: begin
                i_d     = i_q + 8'd1;
                state_d = SI_RD;
            end
            SI_RD: begin
                bus.s_address = i_q;
                state_d       = SI_WT;
            end
            SI_WT: begin
                bus.s_address = i_q;
                state_d       = SI_CAP;
            end
            SI_CAP: begin
                si_d    = bus.s_q;
                j_d     = j_q + bus.s_q;
                state_d = SJ_RD;
            end
            SJ_RD: begin
                bus.s_address = j_q;
                state_d       = SJ_WT;
            end
            SJ_WT: begin
                bus.s_address = j_q;
                state_d       = SJ_CAP;
            end
            SJ_CAP: begin
                sj_d    = bus.s_q;
                state_d = WR_SI;
            end
            WR_SI: begin
                bus.s_address = i_q;
                bus.s_data    = sj_q;
                bus.s_wren    = 1'b1;
                state_d       = WR_SJ;
            end
            WR_SJ: begin
                bus.s_address = j_q;
                bus.s_data    = si_q;
                bus.s_wren    = 1'b1;
                state_d       = F_RD;
            end
            F_RD: begin
                bus.s_address   = si_q + sj_q;
                bus.rom_address = k_q;
                state_d         = F_WT;
            end
            F_WT: begin
                bus.s_address   = si_q + sj_q;
                bus.rom_address = k_q;
                state_d         = F_CAP;
            end
            F_CAP: begin
                f_d     = bus.s_q;
                enc_d   = bus.rom_q;
                state_d = WR_DEC;
            end
            WR_DEC: begin
                bus.dec_address = k_q;
                bus.dec_data    = plain;
                bus.dec_wren    = 1'b1;
                if (k_q == LAST || bad) begin
                    state_d = DONE;
                    kinv_d  = bad;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = I_INC;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt: scoreboard bench for prga_decrypt with MSG_LEN=4 and MSG_LEN=32 instances sharing clock and reset
module tb_prga_decrypt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef VALID_CHECK_EN
    localparam logic [7:0] RX = 8'h60;
`else
    localparam logic [7:0] RX = 8'h00;
`endif

    prga_decrypt_if #(.MSG_AW(5)) b0 ();
    prga_decrypt_if #(.MSG_AW(5)) b1 ();

    prga_decrypt #(.MSG_LEN(4),  .MSG_AW(5)) u0 (.clk(clk), .reset(rst), .bus(b0.master));
    prga_decrypt #(.MSG_LEN(32), .MSG_AW(5)) u1 (.clk(clk), .reset(rst), .bus(b1.master));

    logic [7:0]  s0 [256];
    logic [7:0]  s1 [256];
    logic [7:0]  init0 [256];
    logic [7:0]  init1 [256];
    logic [7:0]  rom0 [32];
    logic [7:0]  rom1 [32];
    logic [12:0] obs0 [1024];
    logic [12:0] obs1 [1024];
    logic [12:0] expq [$];
    int          nobs0 = 0;
    int          nobs1 = 0;
    logic        ld = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    // S-RAM and ROM models with 1-cycle read latency; ld reloads both S-RAMs
    always @(posedge clk) begin
        if (ld) begin
            for (int x = 0; x < 256; x++) begin
                s0[x] <= init0[x];
                s1[x] <= init1[x];
            end
        end else begin
            if (b0.s_wren) s0[b0.s_address] <= b0.s_data;
            if (b1.s_wren) s1[b1.s_address] <= b1.s_data;
        end
        b0.s_q   <= s0[b0.s_address];
        b1.s_q   <= s1[b1.s_address];
        b0.rom_q <= rom0[b0.rom_address];
        b1.rom_q <= rom1[b1.rom_address];
    end

    // records every decrypted-RAM write as {address, data}
    always @(negedge clk) begin
        if (b0.dec_wren) begin
            obs0[nobs0 % 1024] <= {b0.dec_address, b0.dec_data};
            nobs0 <= nobs0 + 1;
        end
        if (b1.dec_wren) begin
            obs1[nobs1 % 1024] <= {b1.dec_address, b1.dec_data};
            nobs1 <= nobs1 + 1;
        end
    end

    task automatic st(input bit u, input logic v);
        if (u) b1.start_sig = v;
        else   b0.start_sig = v;
    endtask

    function automatic logic dn(input bit u);
        return u ? b1.done : b0.done;
    endfunction

    task automatic load();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic load_identity(input logic [7:0] rx);
        for (int x = 0; x < 256; x++) init0[x] = 8'(x);
        for (int x = 0; x < 32; x++) rom0[x] = rx;
        load();
    endtask

    task automatic push_t1();
        logic [7:0] p [4] = '{8'h02, 8'h05, 8'h07, 8'h0D};
        for (int k = 0; k < 4; k++) expq.push_back({5'(k), p[k] ^ RX});
    endtask

    // start (held hold cycles, extra pulse at cycle mid) and count cycles until done; n=2000 means timeout
    task automatic run(input bit u, input int hold, input int mid, output int n);
        @(negedge clk);
        st(u, 1'b1);
        @(posedge clk);
        n = 0;
        while (n < 2000) begin
            #1;
            st(u, (n + 1 < hold) || (n == mid));
            if (n > 0 && dn(u)) break;
            @(posedge clk);
            n++;
        end
        st(u, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st(0, 1'b0);
        st(1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({b0.busy, b0.done, b0.key_invalid, b0.s_wren, b0.dec_wren} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags0 got %b want 00000", {b0.busy, b0.done, b0.key_invalid, b0.s_wren, b0.dec_wren});
        end
        compared++;
        if ({b0.s_address, b0.s_data, b0.rom_address, b0.dec_address, b0.dec_data} !== 34'h0) begin
            mismatched++;
            $display("FAIL reset_bus0 got %h want 0", {b0.s_address, b0.s_data, b0.rom_address, b0.dec_address, b0.dec_data});
        end
        compared++;
        if ({b1.busy, b1.done, b1.key_invalid, b1.s_wren, b1.dec_wren} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags1 got %b want 00000", {b1.busy, b1.done, b1.key_invalid, b1.s_wren, b1.dec_wren});
        end
        compared++;
        if ({b1.s_address, b1.rom_address, b1.dec_address} !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_bus1 got %h want 0", {b1.s_address, b1.rom_address, b1.dec_address});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int n, base;
        logic [12:0] e;
        logic [7:0] want [5] = '{8'h03, 8'h05, 8'h09, 8'h02, 8'h04};
        int addr [5] = '{2, 3, 4, 5, 9};
        load_identity(RX);
        push_t1();
        base = nobs0;
        run(0, 1, -1, n);
        compared++;
        if (n !== 53) begin
            mismatched++;
            $display("FAIL t1_latency got %0d want 53", n);
        end
        compared++;
        if (nobs0 - base !== 4) begin
            mismatched++;
            $display("FAIL t1_writes got %0d want 4", nobs0 - base);
        end
        for (int k = 0; k < 4; k++) begin
            e = expq.pop_front();
            compared++;
            if (obs0[(base + k) % 1024] !== e) begin
                mismatched++;
                $display("FAIL t1_dec%0d got %h want %h", k, obs0[(base + k) % 1024], e);
            end
        end
        for (int x = 0; x < 5; x++) begin
            compared++;
            if (s0[addr[x]] !== want[x]) begin
                mismatched++;
                $display("FAIL t1_S%0d got %h want %h", addr[x], s0[addr[x]], want[x]);
            end
        end
        compared++;
        if (b0.key_invalid !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_key_invalid got %b want 0", b0.key_invalid);
        end
    endtask

`ifdef VALID_CHECK_EN
    task automatic test_abort();
        int n, base;
        load_identity(8'h00);
        expq.push_back({5'd0, 8'h02});
        base = nobs0;
        run(0, 1, -1, n);
        compared++;
        if (n !== 14) begin
            mismatched++;
            $display("FAIL t3_latency got %0d want 14", n);
        end
        repeat (20) @(negedge clk);
        compared++;
        if (nobs0 - base !== 1) begin
            mismatched++;
            $display("FAIL t3_writes got %0d want 1", nobs0 - base);
        end
        compared++;
        if (obs0[base % 1024] !== expq[0]) begin
            mismatched++;
            $display("FAIL t3_dec0 got %h want %h", obs0[base % 1024], expq[0]);
        end
        void'(expq.pop_front());
        compared++;
        if ({b0.done, b0.key_invalid} !== 2'b11) begin
            mismatched++;
            $display("FAIL t3_done_kinv got %b want 11", {b0.done, b0.key_invalid});
        end
    endtask
`endif

    task automatic test_ascii();
        int n, base;
        logic [7:0] r [4] = '{8'h63, 8'h64, 8'h66, 8'h6C};
        load_identity(8'h00);
        for (int k = 0; k < 4; k++) rom0[k] = r[k];
        for (int k = 0; k < 4; k++) expq.push_back({5'(k), 8'h61});
        base = nobs0;
        run(0, 1, -1, n);
        compared++;
        if (n !== 53) begin
            mismatched++;
            $display("FAIL t2_latency got %0d want 53", n);
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (obs0[(base + k) % 1024] !== expq[0]) begin
                mismatched++;
                $display("FAIL t2_dec%0d got %h want %h", k, obs0[(base + k) % 1024], expq[0]);
            end
            void'(expq.pop_front());
        end
        compared++;
        if ({b0.done, b0.key_invalid} !== 2'b10) begin
            mismatched++;
            $display("FAIL t2_done_kinv got %b want 10", {b0.done, b0.key_invalid});
        end
    endtask

    task automatic test_start_ignored();
        int n, base;
        load_identity(RX);
        push_t1();
        base = nobs0;
        run(0, 3, 20, n);
        compared++;
        if (n !== 53) begin
            mismatched++;
            $display("FAIL t4_latency got %0d want 53", n);
        end
        compared++;
        if (nobs0 - base !== 4) begin
            mismatched++;
            $display("FAIL t4_writes got %0d want 4", nobs0 - base);
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (obs0[(base + k) % 1024] !== expq[0]) begin
                mismatched++;
                $display("FAIL t4_dec%0d got %h want %h", k, obs0[(base + k) % 1024], expq[0]);
            end
            void'(expq.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        int n, base;
        bit hit = 1'b0;
        load_identity(RX);
        base = nobs0;
        @(negedge clk);
        st(0, 1'b1);
        @(posedge clk);
        #1;
        st(0, 1'b0);
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = b0.s_wren && b0.s_address == 8'd3 && b0.s_data == 8'd5;
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("FAIL t5_reach_wr_si got 0 want 1");
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({b0.busy, b0.done, b0.key_invalid, b0.s_wren, b0.dec_wren} !== 5'b0) begin
            mismatched++;
            $display("FAIL t5_flags got %b want 00000", {b0.busy, b0.done, b0.key_invalid, b0.s_wren, b0.dec_wren});
        end
        compared++;
        if ({b0.s_address, b0.s_data, b0.rom_address, b0.dec_address, b0.dec_data} !== 34'h0) begin
            mismatched++;
            $display("FAIL t5_bus got %h want 0", {b0.s_address, b0.s_data, b0.rom_address, b0.dec_address, b0.dec_data});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        compared++;
        if (nobs0 - base !== 2 || b0.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL t5_after_reset got writes=%0d busy=%b want writes=2 busy=0", nobs0 - base, b0.busy);
        end
        load_identity(RX);
        push_t1();
        base = nobs0;
        run(0, 1, -1, n);
        compared++;
        if (n !== 53) begin
            mismatched++;
            $display("FAIL t5_latency got %0d want 53", n);
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (obs0[(base + k) % 1024] !== expq[0]) begin
                mismatched++;
                $display("FAIL t5_dec%0d got %h want %h", k, obs0[(base + k) % 1024], expq[0]);
            end
            void'(expq.pop_front());
        end
    endtask

    task automatic test_wrap();
        int n, base;
        logic [7:0] m [256];
        logic [7:0] i, j, t, p, ks;
        for (int x = 0; x < 256; x++) init1[x] = 8'(255 - x);
        for (int x = 0; x < 256; x++) m[x] = 8'(255 - x);
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < 32; k++) begin
            i = i + 8'd1;
            j = j + m[i];
            t = m[i];
            m[i] = m[j];
            m[j] = t;
            ks = m[8'(m[i] + m[j])];
`ifdef VALID_CHECK_EN
            p = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'($urandom_range(8'h61, 8'h7A));
`else
            p = 8'($urandom);
`endif
            rom1[k] = ks ^ p;
            expq.push_back({5'(k), p});
        end
        load();
        base = nobs1;
        run(1, 1, -1, n);
        compared++;
        if (n !== 417) begin
            mismatched++;
            $display("FAIL t6_latency got %0d want 417", n);
        end
        compared++;
        if (nobs1 - base !== 32) begin
            mismatched++;
            $display("FAIL t6_writes got %0d want 32", nobs1 - base);
        end
        for (int k = 0; k < 32; k++) begin
            compared++;
            if (obs1[(base + k) % 1024] !== expq[0]) begin
                mismatched++;
                $display("FAIL t6_dec%0d got %h want %h", k, obs1[(base + k) % 1024], expq[0]);
            end
            void'(expq.pop_front());
        end
        for (int x = 0; x < 256; x++) begin
            compared++;
            if (s1[x] !== m[x]) begin
                mismatched++;
                $display("FAIL t6_S%0d got %h want %h", x, s1[x], m[x]);
            end
        end
    endtask

    initial begin
        b0.start_sig = 1'b0;
        b1.start_sig = 1'b0;
        test_reset();
        test_identity();
`ifdef VALID_CHECK_EN
        test_abort();
`endif
        test_ascii();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
